// File: rtl/ponto_pkg.sv
// Shared definitions for the point-strobe sender: coordinate width, table
// depth, table index names, FSM state encoding and the stored point record.
package ponto_pkg;

  localparam int W     = 10;
  localparam int NPTS  = 4;
  localparam int IDX_W = 2;

  localparam logic [IDX_W-1:0] IDX_P1 = 2'd0;
  localparam logic [IDX_W-1:0] IDX_P2 = 2'd1;
  localparam logic [IDX_W-1:0] IDX_P3 = 2'd2;
  localparam logic [IDX_W-1:0] IDX_PT = 2'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    TAIL   = 3'd3,
    DONE   = 3'd4
  } state_t;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
  } point_t;

endpackage

// File: rtl/ponto_phase_timer.sv
// Loadable down-counter timing the SETUP, STROBE and TAIL phases. A load of
// N makes expire go high in the N-th cycle after the load edge, so the phase
// that issued the load lasts exactly N cycles.
module ponto_phase_timer #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          expire
);

  logic [CW-1:0] cnt_reg;

  // Count down to zero; a load always wins over the decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  // Last cycle of the current phase; a parked counter (0) never expires.
  assign expire = (cnt_reg == CW'(1));

endmodule

// File: rtl/ponto_sender.sv
// Point-strobe transmitter: holds a 4-entry point table written by the host
// and, on start, replays it as strobed px/py points with selPonto framed by
// LOW_CYC cycles of setup before and HIGH_CYC cycles of strobe per point.
module ponto_sender
  import ponto_pkg::*;
#(
  parameter int LOW_CYC  = 2,
  parameter int HIGH_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [W-1:0]     wr_x,
  input  logic [W-1:0]     wr_y,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     px,
  output logic [W-1:0]     py,
  output logic             selPonto
);

  localparam int CW = $clog2((LOW_CYC > HIGH_CYC) ? LOW_CYC : HIGH_CYC) + 1;

  if (LOW_CYC < 1 || HIGH_CYC < 1) begin : g_param_check
    $error("ponto_sender: LOW_CYC and HIGH_CYC must both be >= 1");
  end

  state_t           state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [IDX_W-1:0] idx_next;
  point_t           tbl [NPTS];
  point_t           first_pt;
  logic             tbl_we;
  logic             tmr_load;
  logic [CW-1:0]    tmr_val;
  logic             tmr_expire;

  // The table only accepts writes while no transfer is running.
  assign tbl_we   = wr_en && !busy;
  assign idx_next = idx_reg + 1'b1;

  // A write to P1 in the same cycle as start must be the value sent first.
  assign first_pt = (tbl_we && wr_idx == IDX_P1) ? point_t'({wr_x, wr_y}) : tbl[0];

  // One flop bank per table entry, each decoding its own write address.
  for (genvar gi = 0; gi < NPTS; gi++) begin : g_tbl
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tbl[gi] <= '0;
      end else if (tbl_we && wr_idx == IDX_W'(gi)) begin
        tbl[gi] <= '{x: wr_x, y: wr_y};
      end
    end
  end

  ponto_phase_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  // Arm the phase timer on every edge that enters a timed phase.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = CW'(LOW_CYC);
    case (state_reg)
      IDLE:    tmr_load = start;
      SETUP:   begin tmr_load = tmr_expire; tmr_val = CW'(HIGH_CYC); end
      STROBE:  tmr_load = tmr_expire;
      default: tmr_load = 1'b0;
    endcase
  end

  // Transfer sequencer with registered outputs; px/py move only on SETUP entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      selPonto  <= 1'b0;
      px        <= '0;
      py        <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= SETUP;
            idx_reg   <= '0;
            busy      <= 1'b1;
            selPonto  <= 1'b0;
            px        <= first_pt.x;
            py        <= first_pt.y;
          end
        end
        SETUP: begin
          if (tmr_expire) begin
            state_reg <= STROBE;
            selPonto  <= 1'b1;
          end
        end
        STROBE: begin
          if (tmr_expire) begin
            selPonto <= 1'b0;
            if (idx_reg == IDX_W'(NPTS - 1)) begin
              state_reg <= TAIL;
            end else begin
              state_reg <= SETUP;
              idx_reg   <= idx_next;
              px        <= tbl[idx_next].x;
              py        <= tbl[idx_next].y;
            end
          end
        end
        TAIL: begin
          if (tmr_expire) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          selPonto  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ponto_sender.sv
// Directed bench for ponto_sender: table-driven transfers plus hand-written
// sequences for writes/starts during busy, same-cycle write+start, reset in
// mid-transfer and start held high. Cycle c of a transfer is the interval
// after clock edge c-1, where edge 0 is the edge that samples start.
module tb_ponto_sender;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_idx = '0;
  logic [9:0]  wr_x = '0;
  logic [9:0]  wr_y = '0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [9:0]  px;
  logic [9:0]  py;
  logic        selPonto;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int NCYC = 24;

  typedef struct packed {
    logic            load;
    logic [3:0][9:0] x;   // x[0]=P1 .. x[3]=PT
    logic [3:0][9:0] y;
  } vec_t;

  vec_t vecs [3];
  vec_t cur;

  logic       s_sel  [0:NCYC];
  logic       s_busy [0:NCYC];
  logic       s_done [0:NCYC];
  logic [9:0] s_px   [0:NCYC];
  logic [9:0] s_py   [0:NCYC];

  ponto_sender dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_x     (wr_x),
    .wr_y     (wr_y),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .px       (px),
    .py       (py),
    .selPonto (selPonto)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_table(input vec_t v);
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      wr_en  = 1'b1;
      wr_idx = 2'(p);
      wr_x   = v.x[p];
      wr_y   = v.y[p];
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Start a transfer at the next edge and record NCYC cycles of outputs.
  // poke=1 also writes (9,9) to P1 and pulses start while busy, then holds
  // start across the TAIL and DONE edges.
  task automatic run(input bit poke);
    start     = 1'b1;
    s_sel[0]  = selPonto;
    s_busy[0] = busy;
    s_done[0] = done;
    s_px[0]   = px;
    s_py[0]   = py;
    @(posedge clk);
    for (int c = 1; c <= NCYC; c++) begin
      @(negedge clk);
      s_sel[c]  = selPonto;
      s_busy[c] = busy;
      s_done[c] = done;
      s_px[c]   = px;
      s_py[c]   = py;
      if (c == 1) begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      if (poke) begin
        case (c)
          5:  begin wr_en = 1'b1; wr_idx = 2'd0; wr_x = 10'd9; wr_y = 10'd9; start = 1'b1; end
          6:  begin wr_en = 1'b0; start = 1'b0; end
          10: start = 1'b1;
          11: start = 1'b0;
          18: start = 1'b1;
          20: start = 1'b0;
          default: ;
        endcase
      end
    end
  endtask

  task automatic check_transfer(input string tag, input vec_t v);
    int rises = 0;
    int dones = 0;
    int busys = 0;
    for (int c = 1; c <= NCYC; c++) begin
      if (s_sel[c] && !s_sel[c-1]) rises++;
      if (s_done[c]) dones++;
      if (s_busy[c]) busys++;
    end
    chk($sformatf("%s rise_count", tag), rises, 4);
    chk($sformatf("%s done_count", tag), dones, 1);
    chk($sformatf("%s done_at_19", tag), int'(s_done[19]), 1);
    chk($sformatf("%s busy_count", tag), busys, 18);
    chk($sformatf("%s busy_c1", tag), int'(s_busy[1]), 1);
    chk($sformatf("%s busy_c19", tag), int'(s_busy[19]), 0);
    for (int p = 0; p < 4; p++) begin
      int r = 3 + 4 * p;
      chk($sformatf("%s p%0d rise_at_%0d", tag, p, r), int'(s_sel[r] && !s_sel[r-1]), 1);
      chk($sformatf("%s p%0d sel_fall", tag, p), int'(s_sel[r+2]), 0);
      // Coordinates stable from two cycles before the rise to the last high cycle.
      for (int k = r - 2; k <= r + 1; k++) begin
        chk($sformatf("%s p%0d px_c%0d", tag, p, k), int'(s_px[k]), int'(v.x[p]));
        chk($sformatf("%s p%0d py_c%0d", tag, p, k), int'(s_py[k]), int'(v.y[p]));
      end
    end
    chk($sformatf("%s tail_px", tag), int'(s_px[18]), int'(v.x[3]));
    chk($sformatf("%s tail_py", tag), int'(s_py[18]), int'(v.y[3]));
    chk($sformatf("%s tail_sel", tag), int'(s_sel[17] | s_sel[18]), 0);
    $display("[TB] transfer %s: rises=%0d dones=%0d busy_cycles=%0d", tag, rises, dones, busys);
  endtask

  initial begin
    int cnt_busy;
    int cnt_done;
    int rises;
    int gap;
    int min_gap;
    int seen_transfer;

    // Vector table: expected points equal the loaded points.
    vecs[0].load = 1'b0;                       // empty table after reset
    vecs[0].x = '0;
    vecs[0].y = '0;
    vecs[1].load = 1'b1;                       // extremes
    vecs[1].x = {10'd1, 10'd512, 10'd7, 10'd1023};
    vecs[1].y = {10'd1023, 10'd256, 10'd1000, 10'd5};
    vecs[2].load = 1'b1;                       // P1=(2,2) P2=(0,0) P3=(4,0) PT=(3,1)
    vecs[2].x = {10'd3, 10'd4, 10'd0, 10'd2};
    vecs[2].y = {10'd1, 10'd0, 10'd0, 10'd2};

    // Reset state, asserted asynchronously before any edge.
    #1;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset sel", int'(selPonto), 0);
    chk("reset px", int'(px), 0);
    chk("reset py", int'(py), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      if (vecs[i].load) load_table(vecs[i]);
      run(1'b0);
      check_transfer($sformatf("vec%0d", i), vecs[i]);
    end

    // Writes and starts while busy are dropped; start in TAIL/DONE is ignored.
    run(1'b1);
    check_transfer("busy_poke", vecs[2]);
    for (int c = 21; c <= NCYC; c++)
      chk($sformatf("busy_poke no_restart_c%0d", c), int'(s_busy[c]), 0);
    run(1'b0);
    check_transfer("after_poke", vecs[2]);

    // Same-cycle write and start: the new P1 is sent.
    cur = vecs[2];
    cur.x[0] = 10'd6;
    cur.y[0] = 10'd8;
    wr_en  = 1'b1;
    wr_idx = 2'd0;
    wr_x   = 10'd6;
    wr_y   = 10'd8;
    run(1'b0);
    check_transfer("wr_with_start", cur);

    // Reset in mid-transfer while P2=(7,1000) is being strobed.
    load_table(vecs[1]);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    chk("midrst pre sel", int'(selPonto), 1);
    chk("midrst pre px", int'(px), 7);
    rst_n = 1'b0;
    #1;
    chk("midrst sel", int'(selPonto), 0);
    chk("midrst busy", int'(busy), 0);
    chk("midrst px", int'(px), 0);
    chk("midrst py", int'(py), 0);
    chk("midrst done", int'(done), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_busy = 0;
    cnt_done = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (busy) cnt_busy++;
      if (done) cnt_done++;
    end
    chk("midrst no_busy_after", cnt_busy, 0);
    chk("midrst no_done_after", cnt_done, 0);
    $display("[TB] transfer midrst: busy_after=%0d done_after=%0d", cnt_busy, cnt_done);
    run(1'b0);
    check_transfer("after_midrst", vecs[0]);

    // start held high for 50 cycles: transfers back to back.
    start = 1'b1;
    cnt_done = 0;
    rises = 0;
    gap = 0;
    min_gap = 1000;
    seen_transfer = 0;
    s_sel[0] = selPonto;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (selPonto && !s_sel[0]) rises++;
      s_sel[0] = selPonto;
      if (done) begin
        cnt_done++;
        chk($sformatf("held done_not_busy_c%0d", c), int'(busy), 0);
      end
      if (busy) begin
        if (seen_transfer != 0 && gap > 0 && gap < min_gap) min_gap = gap;
        seen_transfer = 1;
        gap = 0;
      end else begin
        gap++;
      end
    end
    start = 1'b0;
    chk("held done_count", cnt_done, 2);
    chk("held rise_count", rises, 10);
    chk("held min_idle_gap", min_gap, 2);
    $display("[TB] transfer held_start: dones=%0d rises=%0d min_gap=%0d", cnt_done, rises, min_gap);
    repeat (30) @(negedge clk);
    chk("held settles_idle", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
